// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: loads weights, streams
// activation rows, and writes back results once they emerge from the array.
module systolic_ctrl #(
    parameter int unsigned N       = 4,
    parameter int unsigned LAT     = 2 * N,
    parameter int unsigned ROW_W   = 16,
    localparam int unsigned WtAddrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               reuse_wt_i,
    input  logic [ROW_W-1:0]   num_rows_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               wt_rd_en_o,
    output logic [WtAddrW-1:0] wt_rd_addr_o,
    output logic               wt_load_o,
    output logic               act_rd_en_o,
    output logic [ROW_W-1:0]   act_rd_addr_o,
    output logic               out_wr_en_o,
    output logic [ROW_W-1:0]   out_wr_addr_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWload,
        StWsettle,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 wt_rd_en_q;
    logic [WtAddrW-1:0]   wt_rd_addr_q;
    logic                 wt_load_q;
    logic                 act_rd_en_q;
    logic [ROW_W-1:0]     act_rd_addr_q;
    logic [ROW_W-1:0]     out_wr_addr_q;
    logic [ROW_W-1:0]     rows_q;
    logic [ROW_W-1:0]     wr_cnt_q;
    logic [1:0]           settle_q;
    // Bit k is act_rd_en delayed k+1 cycles; the top bit is the write strobe.
    logic [LAT-1:0]       wr_sr_q;

    // Job FSM, weight-load alignment, result delay line and write addressing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wt_rd_en_q    <= 1'b0;
            wt_rd_addr_q  <= '0;
            wt_load_q     <= 1'b0;
            act_rd_en_q   <= 1'b0;
            act_rd_addr_q <= '0;
            out_wr_addr_q <= '0;
            rows_q        <= '0;
            wr_cnt_q      <= '0;
            settle_q      <= '0;
            wr_sr_q       <= '0;
        end else begin
            // Weight capture lines up with read data returning one cycle later.
            wt_load_q <= wt_rd_en_q;
            wr_sr_q   <= {wr_sr_q[LAT-2:0], act_rd_en_q};
            done_q    <= 1'b0;

            // Address is set one cycle ahead so it is valid with the write strobe.
            if (wr_sr_q[LAT-2]) begin
                out_wr_addr_q <= wr_cnt_q;
                wr_cnt_q      <= wr_cnt_q + ROW_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        rows_q   <= num_rows_i;
                        wr_cnt_q <= '0;
                        busy_q   <= 1'b1;
                        if (num_rows_i == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (reuse_wt_i) begin
                            state_q       <= StStream;
                            act_rd_en_q   <= 1'b1;
                            act_rd_addr_q <= '0;
                        end else begin
                            state_q      <= StWload;
                            wt_rd_en_q   <= 1'b1;
                            wt_rd_addr_q <= WtAddrW'(N - 1);
                        end
                    end
                end
                StWload: begin
                    // Rows are fed last-first so they shift into their home rows.
                    if (wt_rd_addr_q == '0) begin
                        state_q    <= StWsettle;
                        wt_rd_en_q <= 1'b0;
                        settle_q   <= '0;
                    end else begin
                        wt_rd_addr_q <= wt_rd_addr_q - WtAddrW'(1);
                    end
                end
                StWsettle: begin
                    // Last data return plus the two-stage MAC weight register.
                    if (settle_q == 2'd2) begin
                        state_q       <= StStream;
                        act_rd_en_q   <= 1'b1;
                        act_rd_addr_q <= '0;
                    end else begin
                        settle_q <= settle_q + 2'd1;
                    end
                end
                StStream: begin
                    if (act_rd_addr_q == rows_q - ROW_W'(1)) begin
                        state_q     <= StDrain;
                        act_rd_en_q <= 1'b0;
                    end else begin
                        act_rd_addr_q <= act_rd_addr_q + ROW_W'(1);
                    end
                end
                StDrain: begin
                    if (wr_sr_q[LAT-1] && (out_wr_addr_q == rows_q - ROW_W'(1))) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign wt_rd_en_o    = wt_rd_en_q;
    assign wt_rd_addr_o  = wt_rd_addr_q;
    assign wt_load_o     = wt_load_q;
    assign act_rd_en_o   = act_rd_en_q;
    assign act_rd_addr_o = act_rd_addr_q;
    assign out_wr_en_o   = wr_sr_q[LAT-1];
    assign out_wr_addr_o = out_wr_addr_q;

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter: N, 4, array dimension (N x N weight-stationary MAC grid).
REQ-002 Parameter: LAT, 2*N, cycles from act_rd_en to matching out_wr_en (buffer read + skew + array traversal).
REQ-003 Parameter: ROW_W, 16, width of row count and row addresses.
REQ-004 Ports: clk  in  1  clock, all logic on rising edge.
REQ-005 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: start  in  1  job request, sampled only in IDLE.
REQ-007 Ports: reuse_wt  in  1  at start: skip weight load and keep resident weights.
REQ-008 Ports: num_rows  in  ROW_W  activation vectors in the job (M), latched at start.
REQ-009 Ports: busy  out  1  high in every state except IDLE.
REQ-010 Ports: done  out  1  one-cycle job-complete pulse.
REQ-011 Ports: wt_rd_en  out  1  weight-buffer read strobe; read data is returned 1 cycle later.
REQ-012 Ports: wt_rd_addr  out  clog2(N)  weight row address.
REQ-013 Ports: wt_load  out  1  broadcast MAC weight-capture control.
REQ-014 Ports: act_rd_en  out  1  activation-buffer read strobe.
REQ-015 Ports: act_rd_addr  out  ROW_W  activation row address.
REQ-016 Ports: out_wr_en  out  1  result-buffer write strobe.
REQ-017 Ports: out_wr_addr  out  ROW_W  result row address.

Function
REQ-018 FSM states: IDLE, WLOAD, WSETTLE, STREAM, DRAIN, DONE; all outputs registered.
REQ-019 IDLE: start=1, num_rows=0 -> DONE; start=1, reuse_wt=1 -> STREAM; start=1 otherwise -> WLOAD; start in any other state ignored.
REQ-020 WLOAD: exactly N cycles, wt_rd_en=1, wt_rd_addr=N-1 down to 0 (reverse order, so row r of array holds row r after shift), then -> WSETTLE.
REQ-021 wt_load = wt_rd_en delayed 1 cycle (aligned to returned data): high exactly N cycles, never otherwise.
REQ-022 WSETTLE: exactly 3 cycles (last data return + 2-stage MAC weight register), then -> STREAM.
REQ-023 STREAM: exactly M cycles, act_rd_en=1, act_rd_addr=0..M-1 incrementing by 1, then -> DRAIN.
REQ-024 out_wr_en = act_rd_en delayed exactly LAT cycles via LAT-deep shift register; out_wr_addr counts 0..M-1, one per write.
REQ-025 DRAIN: held until cycle of last write (out_wr_addr=M-1, out_wr_en=1), then -> DONE.
REQ-026 DONE: one cycle, done=1, busy=1, -> IDLE.
REQ-027 Addresses hold last value when strobes low; M=2^ROW_W-1 supported with no counter wrap.
REQ-028 Exactly M writes per job; no write occurs outside STREAM/DRAIN window.

Reset
REQ-029 rst_n low: immediately state=IDLE, busy, done, wt_rd_en, wt_load, act_rd_en, out_wr_en=0, all addresses and counters 0, delay shift register cleared.
REQ-030 Reset mid-job: no strobe pulses after rst_n deassertion until a new start; resident weights are undefined, so the first job after reset SHALL NOT use reuse_wt=1.

Verification (N=4, LAT=8, start sampled at cycle 0)
REQ-031 reuse_wt=0, num_rows=3 -> wt_rd_addr 3,2,1,0 cycles 1-4; wt_load cycles 2-5; act_rd_addr 0,1,2 cycles 8-10; out_wr_addr 0,1,2 cycles 16-18; done cycle 19; busy cycles 1-19.
REQ-032 reuse_wt=1, num_rows=1 -> no wt_rd_en/wt_load; act_rd_en cycle 1; out_wr_en cycle 9; done cycle 10.
REQ-033 num_rows=0 -> done cycle 1, no rd/wr/wt_load strobes.
REQ-034 start pulsed at cycles 0 and 5 (job num_rows=3) -> second start ignored; single done cycle 19; three writes total.
REQ-035 rst_n low at cycle 12 of REQ-031 job -> all outputs 0 same cycle; zero out_wr_en afterwards; new job after release matches REQ-031 timing.
REQ-036 Back-to-back: start at cycle 20 after REQ-031 job -> accepted; timing identical to REQ-031 offset by 20.
